// File: rtl/bridge_cmd_dispatch_pkg.sv
// bridge_pkg: host command codes, handler indices, result codes and decode helper
package bridge_pkg;
  localparam logic [15:0] HOST_CMD_REQUEST_STATUS = 16'h0000;
  localparam logic [15:0] HOST_CMD_RESET_ENTER = 16'h0010;
  localparam logic [15:0] HOST_CMD_RESET_EXIT = 16'h0011;
  localparam logic [15:0] HOST_CMD_DATASLOT_READ = 16'h0080;
  localparam logic [15:0] HOST_CMD_DATASLOT_WRITE = 16'h0082;
  localparam logic [15:0] HOST_CMD_DATASLOT_COMPLETE = 16'h008A;
  localparam int NUM_CMDS = 5;
  typedef enum logic [2:0] {
    RESET_ENTER = 3'd0,
    RESET_EXIT = 3'd1,
    DATASLOT_READ = 3'd2,
    DATASLOT_WRITE = 3'd3,
    DATASLOT_COMPLETE = 3'd4
  } host_cmd_idx_e;
  typedef enum logic [1:0] {OK = 2'd0, REJECT = 2'd1, UNKNOWN = 2'd2, TIMEOUT = 2'd3} host_cmd_result_e;
  typedef enum logic [1:0] {IDLE, DECODE, DISPATCH, RESPOND} disp_state_e;
  typedef struct packed {
    logic known;
    logic internal;
    host_cmd_idx_e idx;
  } host_cmd_dec_t;
  function automatic host_cmd_dec_t host_cmd_decode(input logic [15:0] code);
    host_cmd_dec_t d;
    d = '{known: 1'b1, internal: 1'b0, idx: RESET_ENTER};
    case (code)
      HOST_CMD_REQUEST_STATUS: d.internal = 1'b1;
      HOST_CMD_RESET_ENTER: d.idx = RESET_ENTER;
      HOST_CMD_RESET_EXIT: d.idx = RESET_EXIT;
      HOST_CMD_DATASLOT_READ: d.idx = DATASLOT_READ;
      HOST_CMD_DATASLOT_WRITE: d.idx = DATASLOT_WRITE;
      HOST_CMD_DATASLOT_COMPLETE: d.idx = DATASLOT_COMPLETE;
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/bridge_cmd_dispatch_if.sv
// bridge_cmd_dispatch_if: host command and response handshakes
interface bridge_cmd_dispatch_if;
  logic cmd_valid;
  logic cmd_ready;
  logic [15:0] cmd_word;
  logic resp_valid;
  logic resp_ready;
  logic [31:0] resp_result;
  logic [31:0] resp_data;
  modport master(
    output cmd_valid, cmd_word, resp_ready,
    input cmd_ready, resp_valid, resp_result, resp_data
  );
  modport slave(
    input cmd_valid, cmd_word, resp_ready,
    output cmd_ready, resp_valid, resp_result, resp_data
  );
endinterface

// File: rtl/bridge_cmd_dispatch_param_buf.sv
// bridge_cmd_param_buf: staging parameter RAM plus snapshot register for the core
module bridge_cmd_param_buf #(
  parameter int PARAM_WORDS = 8,
  localparam int AW = $clog2(PARAM_WORDS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [31:0] wdata,
  input  logic snap,
  output logic [32*PARAM_WORDS-1:0] param
);
  logic [31:0] stage [PARAM_WORDS];
  logic [31:0] held [PARAM_WORDS];
  logic [31:0] nxt [PARAM_WORDS];
  // a write in the snapshot cycle is forwarded into the snapshot
  always_comb
    for (int i = 0; i < PARAM_WORDS; i++)
      nxt[i] = (we && addr == AW'(i)) ? wdata : stage[i];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < PARAM_WORDS; i++) begin
        stage[i] <= '0;
        held[i] <= '0;
      end
    else
      for (int i = 0; i < PARAM_WORDS; i++) begin
        stage[i] <= nxt[i];
        if (snap) held[i] <= nxt[i];
      end
  for (genvar g = 0; g < PARAM_WORDS; g++) begin : g_word
    assign param[g*32 +: 32] = held[g];
  end
endmodule

// File: rtl/bridge_cmd_dispatch.sv
// bridge_cmd_dispatch: host command responder; BRIDGE_CMD_TIMEOUT_EN bounds the DISPATCH wait
module bridge_cmd_dispatch
  import bridge_pkg::*;
#(
  parameter int PARAM_WORDS = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk,
  input  logic reset_n,
  input  logic param_we,
  input  logic [$clog2(PARAM_WORDS)-1:0] param_addr,
  input  logic [31:0] param_wdata,
  input  logic [31:0] core_status,
  output logic [NUM_CMDS-1:0] core_valid,
  output logic [32*PARAM_WORDS-1:0] core_param,
  input  logic core_done,
  input  logic core_reject,
  bridge_cmd_dispatch_if.slave host
);
  disp_state_e state_q, state_d;
  host_cmd_result_e result_q, result_d;
  logic [31:0] data_q, data_d;
  logic [15:0] cmd_q;
  logic accept, expire;
  host_cmd_dec_t dec;
  assign accept = host.cmd_valid && host.cmd_ready;
  assign dec = host_cmd_decode(cmd_q);
  assign host.cmd_ready = state_q == IDLE;
  assign host.resp_valid = state_q == RESPOND;
  assign host.resp_result = {30'b0, result_q};
  assign host.resp_data = data_q;
  assign core_valid = state_q == DISPATCH ? NUM_CMDS'(1) << dec.idx : '0;
  bridge_cmd_param_buf #(.PARAM_WORDS(PARAM_WORDS)) u_param_buf (
    .clk(clk),
    .reset_n(reset_n),
    .we(param_we),
    .addr(param_addr),
    .wdata(param_wdata),
    .snap(accept),
    .param(core_param)
  );
`ifdef BRIDGE_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // the last DISPATCH cycle is the one whose increment would reach the limit
  assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= state_q == DISPATCH ? cnt_q + 1'b1 : '0;
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    data_d = data_q;
    case (state_q)
      IDLE: state_d = host.cmd_valid ? DECODE : IDLE;
      DECODE: begin
        state_d = dec.known && !dec.internal ? DISPATCH : RESPOND;
        result_d = dec.known ? OK : UNKNOWN;
        data_d = dec.internal ? core_status : '0;
      end
      DISPATCH:
        if (core_done || expire) begin
          state_d = RESPOND;
          result_d = !core_done ? TIMEOUT : core_reject ? REJECT : OK;
        end
      RESPOND:
        if (host.resp_ready) begin
          state_d = IDLE;
          result_d = OK;
          data_d = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      result_q <= OK;
      data_q <= '0;
      cmd_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      data_q <= data_d;
      if (accept) cmd_q <= host.cmd_word;
    end
endmodule

// File: tb/tb_bridge_cmd_dispatch.sv
// tb_bridge_cmd_dispatch: directed checks of command dispatch, responses, back-pressure and reset
module tb_bridge_cmd_dispatch;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic param_we = 1'b0;
  logic [2:0] param_addr = '0;
  logic [31:0] param_wdata = '0;
  logic [31:0] core_status = '0;
  logic [4:0] core_valid;
  logic [255:0] core_param;
  logic core_done = 1'b0;
  logic core_reject = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  bridge_cmd_dispatch_if host_if ();
  bridge_cmd_dispatch #(.PARAM_WORDS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .param_we(param_we),
    .param_addr(param_addr),
    .param_wdata(param_wdata),
    .core_status(core_status),
    .core_valid(core_valid),
    .core_param(core_param),
    .core_done(core_done),
    .core_reject(core_reject),
    .host(host_if)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] word(input int i);
    return core_param[i*32 +: 32];
  endfunction
  task automatic write_param(input logic [2:0] a, input logic [31:0] d);
    param_we = 1'b1;
    param_addr = a;
    param_wdata = d;
    @(negedge clk);
    param_we = 1'b0;
  endtask
  task automatic send(input logic [15:0] code);
    int n;
    n = 0;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_word = code;
    while (!host_if.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_bound", 64'(n < 50), 64'(1));
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
  endtask
  task automatic handshake();
    host_if.resp_ready = 1'b1;
    @(negedge clk);
    host_if.resp_ready = 1'b0;
    check("resp_drop", host_if.resp_valid, 0);
    check("idle_ready", host_if.cmd_ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_word = '0;
    host_if.resp_ready = 1'b0;
    #12;
    check("rst_cmd_ready", host_if.cmd_ready, 1);
    check("rst_core_valid", core_valid, 0);
    check("rst_resp_valid", host_if.resp_valid, 0);
    check("rst_resp_result", host_if.resp_result, 0);
    check("rst_resp_data", host_if.resp_data, 0);
    check("rst_core_param", core_param[63:0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // dispatched DATASLOT_READ, completes OK three cycles after core_valid rises
    write_param(3'd0, 32'h11);
    write_param(3'd1, 32'h22);
    send(16'h0080);
    check("t1_decode_cv", core_valid, 0);
    @(negedge clk);
    check("t1_cv", core_valid, 5'b00100);
    repeat (3) @(negedge clk);
    core_done = 1'b1;
    check("t1_cv_held", core_valid, 5'b00100);
    check("t1_word0", word(0), 32'h11);
    check("t1_word1", word(1), 32'h22);
    @(negedge clk);
    core_done = 1'b0;
    check("t1_cv_drop", core_valid, 0);
    check("t1_resp_valid", host_if.resp_valid, 1);
    check("t1_result", host_if.resp_result, 0);
    check("t1_data", host_if.resp_data, 0);
    handshake();
    // REQUEST_STATUS with a param write in the accept cycle
    core_status = 32'h3;
    param_we = 1'b1;
    param_addr = 3'd2;
    param_wdata = 32'h33;
    send(16'h0000);
    param_we = 1'b0;
    check("t2_resp_early", host_if.resp_valid, 0);
    check("t2_word2_snap", word(2), 32'h33);
    check("t2_word0_snap", word(0), 32'h11);
    @(negedge clk);
    check("t2_resp_valid", host_if.resp_valid, 1);
    check("t2_data", host_if.resp_data, 32'h3);
    check("t2_result", host_if.resp_result, 0);
    check("t2_cv", core_valid, 0);
    write_param(3'd0, 32'h99);
    check("t2_word0_stable", word(0), 32'h11);
    handshake();
    // unknown code with resp_ready raised before resp_valid
    send(16'h1234);
    host_if.resp_ready = 1'b1;
    check("t3_cv", core_valid, 0);
    @(negedge clk);
    check("t3_resp_valid", host_if.resp_valid, 1);
    check("t3_result", host_if.resp_result, 2);
    check("t3_data", host_if.resp_data, 0);
    check("t3_cv2", core_valid, 0);
    @(negedge clk);
    host_if.resp_ready = 1'b0;
    check("t3_resp_drop", host_if.resp_valid, 0);
    // RESET_EXIT rejected, response held while a second command waits
    send(16'h0011);
    @(negedge clk);
    check("t4_cv", core_valid, 5'b00010);
    core_done = 1'b1;
    core_reject = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    core_reject = 1'b0;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_word = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", host_if.resp_valid, 1);
      check("t4_hold_result", host_if.resp_result, 1);
      check("t4_busy", host_if.cmd_ready, 0);
      @(negedge clk);
    end
    handshake();
    @(negedge clk);
    host_if.cmd_valid = 1'b0;
    check("t4_second_taken", host_if.cmd_ready, 0);
    @(negedge clk);
    check("t4_second_resp", host_if.resp_valid, 1);
    check("t4_second_data", host_if.resp_data, 32'h3);
    handshake();
`ifdef BRIDGE_CMD_TIMEOUT_EN
    // RESET_ENTER never completes
    send(16'h0010);
    @(negedge clk);
    n = 0;
    while (core_valid[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t5_cv_cycles", n, 16);
    check("t5_resp_valid", host_if.resp_valid, 1);
    check("t5_result", host_if.resp_result, 3);
    handshake();
`endif
    // reset during DISPATCH, then a param rewrite during the next dispatch
    send(16'h0082);
    @(negedge clk);
    check("t6_cv", core_valid, 5'b01000);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_cv", core_valid, 0);
    check("t6_rst_resp", host_if.resp_valid, 0);
    check("t6_rst_ready", host_if.cmd_ready, 1);
    check("t6_rst_param", core_param[63:0], 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_no_stale", host_if.resp_valid, 0);
    write_param(3'd0, 32'h55);
    send(16'h008A);
    @(negedge clk);
    check("t6_cv2", core_valid, 5'b10000);
    check("t6_word0", word(0), 32'h55);
    write_param(3'd0, 32'h66);
    check("t6_word0_stable", word(0), 32'h55);
    check("t6_cv_held", core_valid, 5'b10000);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    check("t6_resp_valid", host_if.resp_valid, 1);
    check("t6_result", host_if.resp_result, 0);
    handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
